// File: rtl/eth_axis_pkt_gen.sv
// eth_axis_pkt_gen: Ethernet test-frame source (no FCS) feeding a 64-bit AXI-Stream MAC tx port; `define TXGEN_ERRINJ_EN adds ErrInj.
// Latency: first beat two clocks after Enable rises (IDLE->LOAD->SEND); IFG_CYCLES idle clocks between frames, LOAD included.
// Backpressure: tready low freezes the current beat; tvalid/tdata/tkeep/tlast hold until the beat is accepted.
module eth_axis_pkt_gen #(
    parameter logic [47:0] DST_MAC    = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC    = 48'h0002_0304_0506,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          IFG_CYCLES = 4
) (
    input  logic        tx_axis_fifo_aclk,
    input  logic        tx_axis_aresetn,
`ifdef TXGEN_ERRINJ_EN
    input  logic        ErrInj,
`endif
    input  logic        Enable,
    input  logic [10:0] PkgLen,
    input  logic [31:0] PkgNum,
    input  logic        CntClr,
    output logic [63:0] tx_axis_fifo_tdata,
    output logic [7:0]  tx_axis_fifo_tkeep,
    output logic        tx_axis_fifo_tvalid,
    output logic        tx_axis_fifo_tlast,
    input  logic        tx_axis_fifo_tready,
    output logic [31:0] TxGen_Cnt,
    output logic        Busy,
    output logic        Done
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

    // LOAD is itself one idle clock, so GAP only covers the remaining IFG_CYCLES-1 clocks.
    localparam logic [15:0] GAP_LAST = (IFG_CYCLES >= 2) ? 16'(IFG_CYCLES - 2) : 16'd0;

    state_t      state_q, state_d;
    logic [31:0] num_q, num_d;
    logic [31:0] run_q, run_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  last_beat_q, last_beat_d;
    logic [7:0]  last_keep_q, last_keep_d;
    logic [15:0] gap_q, gap_d;

    logic [10:0] len_clamped;
    logic        hs;
    logic        err_frame;

    // Clamp the requested length into the legal untagged frame range (no FCS).
    always_comb begin
        len_clamped = PkgLen;
        if (PkgLen < 11'd60) begin
            len_clamped = 11'd60;
        end else if (PkgLen > 11'd1514) begin
            len_clamped = 11'd1514;
        end
    end

    assign tx_axis_fifo_tvalid = (state_q == S_SEND);
    assign tx_axis_fifo_tlast  = tx_axis_fifo_tvalid && (beat_q == last_beat_q);
    assign tx_axis_fifo_tkeep  = !tx_axis_fifo_tvalid ? 8'h00 :
                                 (tx_axis_fifo_tlast ? last_keep_q : 8'hFF);
    assign hs        = tx_axis_fifo_tvalid && tx_axis_fifo_tready;
    assign TxGen_Cnt = cnt_q;
    assign Busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign Done      = (state_q == S_DONE);

    // Beat payload is a pure function of held state, so it stays stable while stalled.
    always_comb begin
        logic [143:0] hdr;
        logic [143:0] hdr_sh;
        logic [10:0]  idx;
        logic [7:0]   b;
        hdr    = {DST_MAC, SRC_MAC, ETHERTYPE, seq_q};
        hdr_sh = '0;
        idx    = '0;
        b      = '0;
        tx_axis_fifo_tdata = '0;
        for (int n = 0; n < 8; n++) begin
            idx    = {beat_q, 3'(n)};
            hdr_sh = hdr << {idx[4:0], 3'b000};
            b      = (idx < 11'd18) ? 8'(hdr_sh >> 136) : idx[7:0];
            if ((idx == 11'd18) && err_frame) begin
                b = ~b;
            end
            if (tx_axis_fifo_tkeep[n]) begin
                tx_axis_fifo_tdata[8*n +: 8] = b;
            end
        end
    end

    // Next-state logic for the run/frame sequencer and the frame counter.
    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        run_d       = run_q;
        seq_d       = seq_q;
        beat_d      = beat_q;
        last_beat_d = last_beat_q;
        last_keep_d = last_keep_q;
        gap_d       = gap_q;
        case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    num_d   = PkgNum;
                    run_d   = '0;
                    seq_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                last_beat_d = 8'((len_clamped - 11'd1) >> 3);
                last_keep_d = (len_clamped[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << len_clamped[2:0]);
                beat_d      = '0;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (hs && !tx_axis_fifo_tlast) begin
                    beat_d = beat_q + 8'd1;
                end else if (hs) begin
                    seq_d = seq_q + 32'd1;
                    run_d = run_q + 32'd1;
                    gap_d = '0;
                    if ((num_q != 32'd0) && (run_q + 32'd1 == num_q)) begin
                        state_d = S_DONE;
                    end else if (!Enable) begin
                        state_d = S_IDLE;
                    end else if (IFG_CYCLES >= 2) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = Enable ? S_LOAD : S_IDLE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_DONE: begin
                if (!Enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clear takes priority over a same-clock frame completion.
        cnt_d = cnt_q;
        if (CntClr) begin
            cnt_d = '0;
        end else if (hs && tx_axis_fifo_tlast) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge tx_axis_fifo_aclk) begin
        if (!tx_axis_aresetn) begin
            state_q     <= S_IDLE;
            num_q       <= '0;
            run_q       <= '0;
            seq_q       <= '0;
            cnt_q       <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            last_keep_q <= '0;
            gap_q       <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            run_q       <= run_d;
            seq_q       <= seq_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            last_beat_q <= last_beat_d;
            last_keep_q <= last_keep_d;
            gap_q       <= gap_d;
        end
    end

`ifdef TXGEN_ERRINJ_EN
    logic arm_q, arm_d;
    logic err_frame_q, err_frame_d;

    // One-shot arm: consumed by the next LOAD; a pulse coinciding with LOAD arms the frame after.
    always_comb begin
        arm_d       = arm_q | ErrInj;
        err_frame_d = err_frame_q;
        if (state_q == S_LOAD) begin
            err_frame_d = arm_q;
            arm_d       = ErrInj;
        end
    end

    // Error-injection flags.
    always_ff @(posedge tx_axis_fifo_aclk) begin
        if (!tx_axis_aresetn) begin
            arm_q       <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            arm_q       <= arm_d;
            err_frame_q <= err_frame_d;
        end
    end

    assign err_frame = err_frame_q;
`else
    assign err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_eth_axis_pkt_gen.sv
// tb_eth_axis_pkt_gen: directed checks of eth_axis_pkt_gen frame format, clamping, gaps, counters and reset.
// Latency: n/a (bench).
// Backpressure: drives tready constant-high or randomly toggled per frame.
module tb_eth_axis_pkt_gen;

    logic        clk;
    logic        rst_n;
    logic        err_inj;
    logic        enable;
    logic [10:0] pkg_len;
    logic [31:0] pkg_num;
    logic        cnt_clr;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic [31:0] cnt;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] bt_data [0:255];

    eth_axis_pkt_gen dut (
        .tx_axis_fifo_aclk   (clk),
        .tx_axis_aresetn     (rst_n),
`ifdef TXGEN_ERRINJ_EN
        .ErrInj              (err_inj),
`endif
        .Enable              (enable),
        .PkgLen              (pkg_len),
        .PkgNum              (pkg_num),
        .CntClr              (cnt_clr),
        .tx_axis_fifo_tdata  (tdata),
        .tx_axis_fifo_tkeep  (tkeep),
        .tx_axis_fifo_tvalid (tvalid),
        .tx_axis_fifo_tlast  (tlast),
        .tx_axis_fifo_tready (tready),
        .TxGen_Cnt           (cnt),
        .Busy                (busy),
        .Done                (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int i, input int len, input logic [31:0] seq, input bit inj);
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        dst = 48'hFFFF_FFFF_FFFF;
        src = 48'h0002_0304_0506;
        et  = 16'h88B5;
        if (i >= len)           return 8'h00;
        if (i < 6)              return dst[8*(5-i) +: 8];
        if (i < 12)             return src[8*(11-i) +: 8];
        if (i == 12)            return et[15:8];
        if (i == 13)            return et[7:0];
        if (i < 18)             return seq[8*(17-i) +: 8];
        if ((i == 18) && inj)   return 8'hED;
        return i[7:0];
    endfunction

    // Receive one frame; lat = idle clocks seen before the first beat.
    task automatic recv(input int len, input logic [31:0] seq, input bit inj, input bit rnd,
                        input int drop_at, input bit clr_last, input int pulse_at,
                        output int lat, output int nb, output logic [7:0] lkeep);
        int bad, unstable, bubbles, k, guard;
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl, pv, pr, fin, pulsed;
        bad = 0; unstable = 0; bubbles = 0; k = 0; guard = 0;
        fin = 1'b0; pulsed = 1'b0; lat = 0; lkeep = 8'h00;
        while (!tvalid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("tvalid_start", {63'd0, tvalid}, 64'd1);
        while (!fin && guard < 2000) begin
            tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (k == drop_at) enable = 1'b0;
            if ((k == pulse_at) && !pulsed) begin
                err_inj = 1'b1;
                pulsed  = 1'b1;
            end
            if (clr_last && tlast && tready) cnt_clr = 1'b1;
            if (!tvalid) bubbles++;
            pd = tdata; pk = tkeep; pl = tlast; pv = tvalid; pr = tready;
            @(negedge clk);
            guard++;
            err_inj = 1'b0;
            cnt_clr = 1'b0;
            if (pv && pr) begin
                bt_data[k] = pd;
                for (int n = 0; n < 8; n++) begin
                    if (pd[8*n +: 8] !== exp_byte(k*8 + n, len, seq, inj)) bad++;
                    if (pk[n] !== (k*8 + n < len)) bad++;
                end
                if (pl) begin
                    fin   = 1'b1;
                    lkeep = pk;
                end
                k++;
            end else if (pv) begin
                if (tdata !== pd || tkeep !== pk || tlast !== pl || !tvalid) unstable++;
            end
        end
        nb = k;
        tready = 1'b1;
        chk("frame_end", {63'd0, fin}, 64'd1);
        chk("frame_bytes", 64'(bad), 64'd0);
        chk("frame_bubbles", 64'(bubbles), 64'd0);
        if (rnd) chk("stall_hold", 64'(unstable), 64'd0);
    endtask

    initial begin
        int lat, nb;
        logic [7:0]  lk;
        logic [31:0] sq;
        rst_n = 1'b0; enable = 1'b0; pkg_len = 11'd64; pkg_num = 32'd1;
        cnt_clr = 1'b0; tready = 1'b1; err_inj = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_tlast",  {63'd0, tlast},  64'd0);
        chk("rst_tdata",  tdata, 64'd0);
        chk("rst_tkeep",  {56'd0, tkeep}, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);
        chk("rst_done",   {63'd0, done}, 64'd0);
        chk("rst_cnt",    {32'd0, cnt},  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single 64-byte frame.
        enable = 1'b1;
        recv(64, 32'd0, 1'b0, 1'b0, -1, 1'b0, -1, lat, nb, lk);
        chk("t1_lat",   64'(lat), 64'd2);
        chk("t1_beats", 64'(nb), 64'd8);
        chk("t1_lkeep", {56'd0, lk}, 64'hFF);
        chk("t1_beat0", bt_data[0], 64'h0200_FFFF_FFFF_FFFF);
        chk("t1_beat1", bt_data[1], 64'h0000_B588_0605_0403);
        chk("t1_beat2", bt_data[2], 64'h1716_1514_1312_0000);
        chk("t1_done",  {63'd0, done}, 64'd1);
        chk("t1_busy",  {63'd0, busy}, 64'd0);
        chk("t1_cnt",   {32'd0, cnt},  64'd1);
        enable = 1'b0;
        @(negedge clk);
        chk("t1_idle_done", {63'd0, done}, 64'd0);

        // Length clamps.
        pkg_len = 11'd20; enable = 1'b1;
        recv(60, 32'd0, 1'b0, 1'b0, -1, 1'b0, -1, lat, nb, lk);
        chk("t2_min_beats", 64'(nb), 64'd8);
        chk("t2_min_lkeep", {56'd0, lk}, 64'h0F);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        pkg_len = 11'd2000; enable = 1'b1;
        recv(1514, 32'd0, 1'b0, 1'b0, -1, 1'b0, -1, lat, nb, lk);
        chk("t2_max_beats", 64'(nb), 64'd190);
        chk("t2_max_lkeep", {56'd0, lk}, 64'h03);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Three-frame run with inter-frame gap.
        pkg_len = 11'd100; pkg_num = 32'd3; enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            recv(100, 32'(f), 1'b0, 1'b0, -1, 1'b0, -1, lat, nb, lk);
            sq = {bt_data[1][55:48], bt_data[1][63:56], bt_data[2][7:0], bt_data[2][15:8]};
            chk("t3_seq", {32'd0, sq}, 64'(f));
            chk("t3_lkeep", {56'd0, lk}, 64'h0F);
            if (f > 0) chk("t3_ifg", 64'(lat), 64'd4);
        end
        chk("t3_done", {63'd0, done}, 64'd1);
        chk("t3_cnt",  {32'd0, cnt},  64'd6);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Counter clear, then continuous run with random backpressure; Enable dropped in frame 5.
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("t4_clr", {32'd0, cnt}, 64'd0);
        pkg_len = 11'd77; pkg_num = 32'd0; enable = 1'b1;
        for (int f = 0; f < 5; f++) begin
            recv(77, 32'(f), 1'b0, 1'b1, (f == 4) ? 3 : -1, 1'b0, -1, lat, nb, lk);
            chk("t4_beats", 64'(nb), 64'd10);
            chk("t4_lkeep", {56'd0, lk}, 64'h1F);
        end
        chk("t4_busy",   {63'd0, busy},   64'd0);
        chk("t4_done",   {63'd0, done},   64'd0);
        chk("t4_tvalid", {63'd0, tvalid}, 64'd0);
        chk("t4_cnt",    {32'd0, cnt},    64'd5);

        // CntClr on the tlast handshake clock.
        pkg_len = 11'd60; pkg_num = 32'd1; enable = 1'b1;
        recv(60, 32'd0, 1'b0, 1'b0, -1, 1'b1, -1, lat, nb, lk);
        chk("t5_cnt",  {32'd0, cnt},  64'd0);
        chk("t5_done", {63'd0, done}, 64'd1);
        enable = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of the second frame.
        pkg_len = 11'd200; pkg_num = 32'd0; enable = 1'b1;
        recv(200, 32'd0, 1'b0, 1'b0, -1, 1'b0, -1, lat, nb, lk);
        chk("t6_beats", 64'(nb), 64'd25);
        chk("t6_lkeep", {56'd0, lk}, 64'hFF);
        chk("t6_cnt1",  {32'd0, cnt}, 64'd1);
        lat = 0;
        while (!tvalid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("t6_busy", {63'd0, busy}, 64'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_tvalid", {63'd0, tvalid}, 64'd0);
        chk("t6_tlast",  {63'd0, tlast},  64'd0);
        chk("t6_tdata",  tdata, 64'd0);
        chk("t6_tkeep",  {56'd0, tkeep}, 64'd0);
        chk("t6_rbusy",  {63'd0, busy}, 64'd0);
        chk("t6_rcnt",   {32'd0, cnt},  64'd0);
        rst_n = 1'b1;
        recv(200, 32'd0, 1'b0, 1'b0, -1, 1'b0, -1, lat, nb, lk);
        sq = {bt_data[1][55:48], bt_data[1][63:56], bt_data[2][7:0], bt_data[2][15:8]};
        chk("t6_seq0", {32'd0, sq}, 64'd0);
        enable = 1'b0;
        repeat (8) @(negedge clk);

`ifdef TXGEN_ERRINJ_EN
        // Error-injection pulse during frame 0 corrupts byte 18 of frame 1 only.
        pkg_len = 11'd64; pkg_num = 32'd3; enable = 1'b1;
        recv(64, 32'd0, 1'b0, 1'b0, -1, 1'b0, 2, lat, nb, lk);
        chk("t7_f0_b18", {56'd0, bt_data[2][23:16]}, 64'h12);
        recv(64, 32'd1, 1'b1, 1'b0, -1, 1'b0, -1, lat, nb, lk);
        chk("t7_f1_b18", {56'd0, bt_data[2][23:16]}, 64'hED);
        recv(64, 32'd2, 1'b0, 1'b0, -1, 1'b0, -1, lat, nb, lk);
        chk("t7_f2_b18", {56'd0, bt_data[2][23:16]}, 64'h12);
        enable = 1'b0;
        repeat (2) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
